// File: rtl/pe_row_feeder_pkg.sv
// definition: shared conv-stage widths, PE row geometry and feeder FSM states
package definition;
  localparam int conv4_width = 8;
  localparam int pe_row_len = 4;
  localparam int pe_row_drain = 2;
  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_DRAIN, ST_HOLD} feeder_state_t;
  function automatic int ctr_w(input int max);
    return max > 0 ? $clog2(max + 1) : 1;
  endfunction
endpackage

// File: rtl/pe_row_feeder_ctr.sv
// pe_row_feeder_ctr: clearable up-counter that saturates at MAX
module pe_row_feeder_ctr
  import definition::*;
#(
  parameter int MAX = 3,
  localparam int CW = ctr_w(MAX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [CW-1:0] cnt_o
);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != CW'(MAX)) ? cnt_q + CW'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign cnt_o = cnt_q;
endmodule

// File: rtl/pe_row_feeder.sv
// pe_row_feeder: loads an activation/filter row pair, streams it into the PE row,
// waits out the row's drain latency and holds the resulting psum for a consumer
module pe_row_feeder
  import definition::*;
#(
  parameter int W = conv4_width,
  parameter int N = pe_row_len,
  parameter int DRAIN = pe_row_drain
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ld_valid,
  output logic           ld_ready,
  input  logic [N*W-1:0] ld_act,
  input  logic [N*W-1:0] ld_wgt,
  output logic [W-1:0]   o_r,
  output logic [W-1:0]   o_f,
  output logic           o_en,
  output logic           o_end_pe,
  input  logic [2*W-1:0] i_psum,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*W-1:0] res_data
);
  localparam int EW = ctr_w(N - 1);
  localparam int DW = ctr_w(DRAIN - 1);
  feeder_state_t state_q, state_d;
  logic [N*W-1:0] act_q, wgt_q;
  logic [2*W-1:0] res_q;
  logic ld_ready_q;
  logic [EW-1:0] ecnt;
  logic [DW-1:0] dcnt;
  logic load, stream, drain, elast, dlast;
  assign load   = ld_valid && ld_ready_q;
  assign stream = state_q == ST_STREAM;
  assign drain  = state_q == ST_DRAIN;
  assign elast  = ecnt == EW'(N - 1);
  assign dlast  = dcnt == DW'(DRAIN - 1);
  pe_row_feeder_ctr #(.MAX(N - 1)) u_ectr (
    .clk(clk), .rst(rst), .clr_i(load), .inc_i(stream), .cnt_o(ecnt)
  );
  pe_row_feeder_ctr #(.MAX(DRAIN - 1)) u_dctr (
    .clk(clk), .rst(rst), .clr_i(stream && elast), .inc_i(drain), .cnt_o(dcnt)
  );
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (load) state_d = ST_STREAM;
      ST_STREAM: if (elast) state_d = ST_DRAIN;
      ST_DRAIN:  if (dlast) state_d = ST_HOLD;
      ST_HOLD:   if (res_ready) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end
  // ld_ready is registered from the next state so it stays low through the reset cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      ld_ready_q <= 1'b0;
      act_q      <= '0;
      wgt_q      <= '0;
      res_q      <= '0;
    end else begin
      state_q    <= state_d;
      ld_ready_q <= state_d == ST_IDLE;
      if (load) begin
        act_q <= ld_act;
        wgt_q <= ld_wgt;
      end
      if (drain && dlast) res_q <= i_psum;
    end
  end
  assign ld_ready  = ld_ready_q;
  assign o_en      = stream;
  assign o_end_pe  = stream && elast;
  assign o_r       = stream ? act_q[int'(ecnt)*W +: W] : '0;
  assign o_f       = stream ? wgt_q[int'(ecnt)*W +: W] : '0;
  assign res_valid = state_q == ST_HOLD;
  assign res_data  = res_q;
endmodule

// File: tb/tb_pe_row_feeder.sv
// tb_pe_row_feeder: directed vector bench with a behavioural PE-row MAC model
module tb_pe_row_feeder;
  localparam int W = 8;
  localparam int N = 4;
  localparam int DR = 2;
  typedef logic [N-1:0][W-1:0] row_t;
  typedef struct {
    row_t act;
    row_t wgt;
    logic [2*W-1:0] exp;
    int hold;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ld_valid = 1'b0;
  logic res_ready = 1'b0;
  row_t ld_act = '0;
  row_t ld_wgt = '0;
  logic ld_ready, o_en, o_end_pe, res_valid;
  logic [W-1:0] o_r, o_f;
  logic [2*W-1:0] i_psum, res_data, acc;
  int checks = 0;
  int errors = 0;
  vec_t tbl[6];
  always #5 clk = ~clk;
  pe_row_feeder #(.W(W), .N(N), .DRAIN(DR)) dut (
    .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_act(ld_act), .ld_wgt(ld_wgt), .o_r(o_r), .o_f(o_f), .o_en(o_en),
    .o_end_pe(o_end_pe), .i_psum(i_psum), .res_valid(res_valid),
    .res_ready(res_ready), .res_data(res_data)
  );
  // PE row stand-in: 2W-bit MAC cleared on each accepted load
  always @(posedge clk) begin
    if (rst || (ld_valid && ld_ready)) acc <= '0;
    else if (o_en) acc <= acc + (2*W)'(o_r) * (2*W)'(o_f);
  end
  assign i_psum = acc;
  function automatic row_t mk(input int a0, input int a1, input int a2, input int a3);
    row_t r;
    r[0] = W'(a0);
    r[1] = W'(a1);
    r[2] = W'(a2);
    r[3] = W'(a3);
    return r;
  endfunction
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask
  task automatic step();
    @(negedge clk);
  endtask
  task automatic load(input row_t a, input row_t w);
    int n = 0;
    while (!ld_ready && n < 20) begin
      step();
      n++;
    end
    chk("ld_ready_wait", 32'(ld_ready), 1);
    ld_valid = 1'b1;
    ld_act = a;
    ld_wgt = w;
    step();
    ld_valid = 1'b0;
  endtask
  task automatic stream_chk(input row_t a, input row_t w);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("o_en[%0d]", k), 32'(o_en), 1);
      chk($sformatf("o_r[%0d]", k), 32'(o_r), 32'(a[k]));
      chk($sformatf("o_f[%0d]", k), 32'(o_f), 32'(w[k]));
      chk($sformatf("o_end_pe[%0d]", k), 32'(o_end_pe), 32'(k == N - 1));
      chk($sformatf("ld_ready_stream[%0d]", k), 32'(ld_ready), 0);
      step();
    end
  endtask
  task automatic run_row(input vec_t v);
    load(v.act, v.wgt);
    stream_chk(v.act, v.wgt);
    for (int d = 0; d < DR; d++) begin
      chk("drain_en", 32'({o_en, o_end_pe, o_r, o_f}), 0);
      chk("drain_res_valid", 32'(res_valid), 0);
      step();
    end
    chk("res_valid", 32'(res_valid), 1);
    chk("res_data", 32'(res_data), 32'(v.exp));
    for (int h = 0; h < v.hold; h++) begin
      if (h == v.hold / 2) begin
        ld_valid = 1'b1;
        ld_act = mk(7, 7, 7, 7);
        ld_wgt = mk(7, 7, 7, 7);
      end
      step();
      chk("hold_valid", 32'(res_valid), 1);
      chk("hold_data", 32'(res_data), 32'(v.exp));
      chk("hold_ld_ready", 32'(ld_ready), 0);
    end
    ld_valid = 1'b0;
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    chk("post_res_valid", 32'(res_valid), 0);
    chk("post_ld_ready", 32'(ld_ready), 1);
    chk("post_o_en", 32'(o_en), 0);
  endtask
  initial begin
    int rv_cyc[$];
    logic [2*W-1:0] rv_dat[$];
    int nl;
    int seen;
    tbl[0] = '{mk(1, 2, 3, 4), mk(1, 2, 3, 0), 16'd14, 10};
    tbl[1] = '{mk(1, 1, 1, 1), mk(2, 2, 2, 2), 16'd8, 0};
    tbl[2] = '{mk(255, 0, 0, 0), mk(255, 0, 0, 0), 16'd65025, 0};
    tbl[3] = '{mk(255, 255, 255, 255), mk(255, 255, 255, 255), 16'd63492, 0};
    tbl[4] = '{mk(10, 20, 30, 40), mk(4, 3, 2, 1), 16'd200, 0};
    tbl[5] = '{mk(0, 0, 0, 0), mk(9, 9, 9, 9), 16'd0, 0};
    step();
    chk("rst_ld_ready", 32'(ld_ready), 0);
    chk("rst_outs", 32'({o_en, o_end_pe, o_r, o_f}), 0);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_res_data", 32'(res_data), 0);
    rst = 1'b0;
    step();
    chk("idle_ld_ready", 32'(ld_ready), 1);
    for (int i = 0; i < 6; i++) run_row(tbl[i]);
    // back-to-back: valid and ready held high, two rows
    res_ready = 1'b1;
    nl = 0;
    for (int c = 0; c < 30; c++) begin
      if (res_valid) begin
        rv_cyc.push_back(c);
        rv_dat.push_back(res_data);
      end
      if (ld_ready) begin
        if (nl < 2) begin
          ld_act = nl == 0 ? mk(1, 1, 1, 1) : mk(255, 0, 0, 0);
          ld_wgt = nl == 0 ? mk(2, 2, 2, 2) : mk(255, 0, 0, 0);
          ld_valid = 1'b1;
          nl++;
        end else ld_valid = 1'b0;
      end
      step();
    end
    res_ready = 1'b0;
    ld_valid = 1'b0;
    chk("b2b_count", 32'(rv_cyc.size()), 2);
    if (rv_cyc.size() >= 2) begin
      chk("b2b_res0", 32'(rv_dat[0]), 8);
      chk("b2b_res1", 32'(rv_dat[1]), 65025);
      chk("b2b_period", 32'(rv_cyc[1] - rv_cyc[0]), N + DR + 2);
    end
    // reset while streaming element 2
    load(mk(5, 6, 7, 8), mk(1, 1, 1, 1));
    step();
    step();
    chk("rs_o_r2", 32'(o_r), 7);
    rst = 1'b1;
    step();
    chk("rs_outs", 32'({o_en, o_end_pe, o_r, o_f}), 0);
    chk("rs_res", 32'({res_valid, res_data}), 0);
    chk("rs_ld_ready", 32'(ld_ready), 0);
    rst = 1'b0;
    step();
    chk("rs_ld_ready_after", 32'(ld_ready), 1);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      seen += int'(res_valid) + int'(o_en);
      step();
    end
    chk("rs_no_activity", 32'(seen), 0);
    // reset while holding a result
    load(mk(1, 2, 3, 4), mk(1, 2, 3, 0));
    stream_chk(mk(1, 2, 3, 4), mk(1, 2, 3, 0));
    repeat (DR) step();
    chk("rh_valid", 32'(res_valid), 1);
    chk("rh_data", 32'(res_data), 14);
    rst = 1'b1;
    step();
    chk("rh_res_cleared", 32'({res_valid, res_data}), 0);
    chk("rh_ld_ready", 32'(ld_ready), 0);
    rst = 1'b0;
    step();
    run_row(tbl[4]);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
